// File: rtl/to_case_pkg.sv
// Shared ASCII case constants and conversion helpers used by the
// lowercase and uppercase stream converters.
package to_case_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t ASCII_UPPER_FIRST = 8'h41;
   localparam byte_t ASCII_UPPER_LAST  = 8'h5A;
   localparam byte_t ASCII_LOWER_FIRST = 8'h61;
   localparam byte_t ASCII_LOWER_LAST  = 8'h7A;
   localparam int    CASE_BIT          = 5;

   function automatic logic is_upper(input byte_t b);
      return (b >= ASCII_UPPER_FIRST) && (b <= ASCII_UPPER_LAST);
   endfunction

   function automatic logic is_lower(input byte_t b);
      return (b >= ASCII_LOWER_FIRST) && (b <= ASCII_LOWER_LAST);
   endfunction

   // Upper and lower letters differ only in CASE_BIT, so conversion is a single bit set/clear.
   function automatic byte_t to_lower(input byte_t b);
      byte_t r;
      r = b;
      if (is_upper(b)) r[CASE_BIT] = 1'b1;
      return r;
   endfunction

   function automatic byte_t to_upper(input byte_t b);
      byte_t r;
      r = b;
      if (is_lower(b)) r[CASE_BIT] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO of DEPTH entries with a registered head-of-queue output.
// Pointers carry one extra MSB so full and empty are distinguishable.
module byte_fifo
   import to_case_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  wr_valid_i,
   output logic  wr_ready_o,
   input  byte_t wr_data_i,
   output logic  rd_valid_o,
   input  logic  rd_ready_i,
   output byte_t rd_data_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   byte_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   byte_t            data_q, data_d;
   logic             full, empty, push, pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push  = wr_valid_i && !full;
   assign pop   = rd_ready_i && !empty;

   assign wr_ready_o = !full;
   assign rd_valid_o = !empty;
   assign rd_data_o  = data_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_d   = wr_q + PTR_W'(push);
      rd_d   = rd_q + PTR_W'(pop);
      data_d = data_q;
      // Preload the head register with whatever sits at the front after this cycle;
      // a byte written into an otherwise-empty queue bypasses the array.
      if (wr_d != rd_d) begin
         data_d = (rd_d == wr_q) ? wr_data_i : mem_q[rd_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   // NOTE: the storage array is not reset; pointers define validity, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter: converts on the way into a byte FIFO
// and keeps saturating counts of accepted and modified bytes.
module to_lower_stream
   import to_case_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   input  logic        clr,
   output logic [15:0] byte_count,
   output logic [15:0] conv_count
);

   logic        accept;
   logic [15:0] byte_count_q, byte_count_d;
   logic [15:0] conv_count_q, conv_count_d;

   assign accept = in_valid && in_ready;

   byte_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid_i (in_valid),
      .wr_ready_o (in_ready),
      .wr_data_i  (to_lower(in_data)),
      .rd_valid_o (out_valid),
      .rd_ready_i (out_ready),
      .rd_data_o  (out_data)
   );

   // clr wins over a same-cycle increment; both counters stick at all-ones.
   always_comb begin
      byte_count_d = byte_count_q;
      conv_count_d = conv_count_q;
      if (clr) begin
         byte_count_d = '0;
         conv_count_d = '0;
      end else if (accept) begin
         if (byte_count_q != '1) byte_count_d = byte_count_q + 16'd1;
         if (is_upper(in_data) && (conv_count_q != '1)) conv_count_d = conv_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_count_q <= '0;
         conv_count_q <= '0;
      end else begin
         byte_count_q <= byte_count_d;
         conv_count_q <= conv_count_d;
      end
   end

   assign byte_count = byte_count_q;
   assign conv_count = conv_count_q;

endmodule

// File: tb/tb_to_lower_stream.sv
// Self-checking bench for to_lower_stream against a queue-based reference model.
module tb_to_lower_stream;

   localparam int DEPTH = 4;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [7:0]  in_data;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic        clr;
   logic [15:0] byte_count, conv_count;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [7:0] exp_q[$];
   logic [7:0] exp_last;
   int         exp_bytes, exp_conv;

   to_lower_stream #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .clr        (clr),
      .byte_count (byte_count),
      .conv_count (conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_lower(input logic [7:0] b);
      return (b >= 8'd65 && b <= 8'd90) ? b + 8'd32 : b;
   endfunction

   function automatic logic [7:0] exp_head();
      return (exp_q.size() != 0) ? exp_q[0] : exp_last;
   endfunction

   // Drive one cycle from a negedge to the next and advance the model.
   task automatic tick(input logic v, input logic [7:0] d, input logic r, input logic c,
                       output logic acc);
      logic del;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clr       = c;
      acc = v && (exp_q.size() < DEPTH);
      del = r && (exp_q.size() != 0);
      @(posedge clk);
      if (del) exp_last = exp_q.pop_front();
      if (acc) exp_q.push_back(ref_lower(d));
      if (c) begin
         exp_bytes = 0;
         exp_conv  = 0;
      end else if (acc) begin
         if (exp_bytes < 65535) exp_bytes++;
         if (d >= 8'd65 && d <= 8'd90 && exp_conv < 65535) exp_conv++;
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_last  = 8'h00;
      exp_bytes = 0;
      exp_conv  = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
          byte_count !== 16'd0 || conv_count !== 16'd0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h bc=%0d cc=%0d, expected 1 0 00 0 0",
                  in_ready, out_valid, out_data, byte_count, conv_count);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_upper();
      logic [7:0] din  [4] = '{8'h48, 8'h41, 8'h5A, 8'h47};
      logic [7:0] dout [4] = '{8'h68, 8'h61, 8'h7A, 8'h67};
      logic acc;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, din[i], 1'b1, 1'b0, acc);
         checks++;
         if (out_valid !== 1'b1 || out_data !== dout[i]) begin
            errors++;
            $display("FAIL upper[%0d]: out_valid=%b out_data=%h, expected 1 %h", i, out_valid, out_data, dout[i]);
         end
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0, acc);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h67 || conv_count !== 16'd4 || byte_count !== 16'd4) begin
         errors++;
         $display("FAIL upper_end: out_valid=%b out_data=%h cc=%0d bc=%0d, expected 0 67 4 4",
                  out_valid, out_data, conv_count, byte_count);
      end
   endtask

   task automatic test_passthrough();
      logic [7:0] din [6] = '{8'h40, 8'h5B, 8'h61, 8'h7F, 8'hC1, 8'h28};
      logic acc;
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, din[i], 1'b1, 1'b0, acc);
         checks++;
         if (out_valid !== 1'b1 || out_data !== din[i]) begin
            errors++;
            $display("FAIL pass[%0d]: out_valid=%b out_data=%h, expected 1 %h", i, out_valid, out_data, din[i]);
         end
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0, acc);
      checks++;
      if (conv_count !== 16'd4 || byte_count !== 16'd10) begin
         errors++;
         $display("FAIL pass_counts: cc=%0d bc=%0d, expected 4 10", conv_count, byte_count);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] din [5] = '{8'h4B, 8'h31, 8'h6D, 8'h5A, 8'h41};
      logic acc;
      int idx = 0;
      int got = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         logic r;
         r = (cyc >= 7);
         if (r && exp_q.size() != 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
               errors++;
               $display("FAIL bp_order[%0d]: out_valid=%b out_data=%h, expected 1 %h", got, out_valid, out_data, exp_q[0]);
            end
            got++;
         end
         tick(idx < 5, (idx < 5) ? din[idx] : 8'h00, r, 1'b0, acc);
         if (acc) idx++;
         if (cyc >= 3 && cyc < 7) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h6B) begin
               errors++;
               $display("FAIL bp_hold c%0d: in_ready=%b out_valid=%b out_data=%h, expected 0 1 6b",
                        cyc, in_ready, out_valid, out_data);
            end
         end
      end
      checks++;
      if (got != 5 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: delivered %0d out_valid=%b, expected 5 0", got, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      for (int i = 0; i < 21; i++) begin
         tick(i < 20, 8'($urandom), 1'b1, 1'b0, acc);
         if (i < 20) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_q[0] || exp_q.size() != 1) begin
               errors++;
               $display("FAIL b2b[%0d]: in_ready=%b out_valid=%b out_data=%h, expected 1 1 %h",
                        i, in_ready, out_valid, out_data, exp_head());
            end
         end
      end
   endtask

   task automatic test_random();
      logic acc;
      for (int i = 0; i < 400; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h3E, 8'h5D)) : 8'($urandom);
         tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, acc);
         checks++;
         if (out_valid !== (exp_q.size() != 0) || out_data !== exp_head() ||
             in_ready !== (exp_q.size() < DEPTH) ||
             byte_count !== 16'(exp_bytes) || conv_count !== 16'(exp_conv)) begin
            errors++;
            $display("FAIL rand[%0d]: ov=%b od=%h ir=%b bc=%0d cc=%0d, expected %b %h %b %0d %0d",
                     i, out_valid, out_data, in_ready, byte_count, conv_count,
                     exp_q.size() != 0, exp_head(), exp_q.size() < DEPTH, exp_bytes, exp_conv);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic acc;
      for (int i = 0; i < 3; i++) tick(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, acc);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 ||
          byte_count !== 16'd0 || conv_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: ov=%b ir=%b od=%h bc=%0d cc=%0d, expected 0 1 00 0 0",
                  out_valid, in_ready, out_data, byte_count, conv_count);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0, acc);
         checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL post_reset[%0d]: ov=%b od=%h, expected 0 00", i, out_valid, out_data);
         end
      end
      tick(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h7A || byte_count !== 16'd1 || conv_count !== 16'd1) begin
         errors++;
         $display("FAIL resume: ov=%b od=%h bc=%0d cc=%0d, expected 1 7a 1 1",
                  out_valid, out_data, byte_count, conv_count);
      end
   endtask

   task automatic test_saturation();
      logic acc;
      tick(1'b0, 8'h00, 1'b1, 1'b1, acc);
      for (int i = 0; i < 65540; i++) tick(1'b1, 8'h41, 1'b1, 1'b0, acc);
      checks++;
      if (byte_count !== 16'hFFFF || conv_count !== 16'hFFFF || exp_bytes != 65535) begin
         errors++;
         $display("FAIL saturate: bc=%h cc=%h, expected ffff ffff", byte_count, conv_count);
      end
      tick(1'b1, 8'h42, 1'b0, 1'b1, acc);
      checks++;
      if (byte_count !== 16'd0 || conv_count !== 16'd0) begin
         errors++;
         $display("FAIL clr_priority: bc=%0d cc=%0d, expected 0 0", byte_count, conv_count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== (exp_q.size() != 0) || out_data !== exp_head()) begin
            errors++;
            $display("FAIL clr_fifo[%0d]: ov=%b od=%h, expected %b %h",
                     i, out_valid, out_data, exp_q.size() != 0, exp_head());
         end
         tick(1'b0, 8'h00, 1'b1, 1'b0, acc);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h62) begin
         errors++;
         $display("FAIL clr_drain: ov=%b od=%h, expected 0 62", out_valid, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_upper();
      test_passthrough();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/to_lower_stream.md
TO_LOWER_STREAM -- requirements
Module: to_lower_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning byte-FIFO entry count, a power of 2, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream byte present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a byte.
REQ-006 SHALL have port in_data, input, 8 bits: upstream byte, bit 7 MSB.
REQ-007 SHALL have port out_valid, output, 1 bit: converted byte present.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts a byte.
REQ-009 SHALL have port out_data, output, 8 bits: converted byte.
REQ-010 SHALL have port clr, input, 1 bit: synchronous clear of counters only.
REQ-011 SHALL have port byte_count, output, 16 bits: bytes accepted since reset or clr.
REQ-012 SHALL have port conv_count, output, 16 bits: accepted bytes that were modified.

Function
REQ-013 SHALL treat a byte as accepted in any cycle with in_valid=1 and in_ready=1.
REQ-014 SHALL treat a byte as delivered in any cycle with out_valid=1 and out_ready=1.
REQ-015 SHALL convert in_data in range 0x41..0x5A by setting bit 5 (adding 0x20); all other values pass unchanged, including 0x40, 0x5B, 0x60..0x7F and every byte >= 0x80.
REQ-016 SHALL apply the conversion before the FIFO write; the FIFO stores only converted bytes.
REQ-017 SHALL drive in_ready = 1 exactly when the FIFO holds fewer than DEPTH entries; it SHALL NOT depend combinationally on in_valid.
REQ-018 SHALL present a byte on out_valid/out_data in the cycle after its acceptance cycle (1-cycle latency, no combinational in-to-out path).
REQ-019 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deliver bytes in acceptance order, with no loss or duplication.
REQ-021 SHALL, on a simultaneous accept and deliver, leave occupancy unchanged; when full, deliver frees a slot visible as in_ready=1 on the next cycle only.
REQ-022 SHALL, when empty, drive out_valid=0 and hold out_data at its last value (0x00 after reset).
REQ-023 SHALL wrap read and write pointers modulo DEPTH, using an extra MSB to distinguish full from empty.
REQ-024 SHALL increment byte_count on each accepted byte, and conv_count on each accepted byte in 0x41..0x5A; both saturate at 0xFFFF.
REQ-025 SHALL, on clr=1, load 0 into both counters that cycle, taking priority over any same-cycle increment; FIFO contents are unaffected.

Reset
REQ-026 SHALL, on rst_n low, immediately set FIFO empty, in_ready=1 (after the flops settle), out_valid=0, out_data=0x00, byte_count=0, conv_count=0.
REQ-027 SHALL discard all buffered bytes on reset mid-stream; no byte accepted before reset is delivered after it.
REQ-028 SHALL resume accepting on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take constants ASCII_UPPER_FIRST=0x41, ASCII_UPPER_LAST=0x5A and CASE_BIT=5 from a shared package, to_case_pkg, which the uppercase converter also uses.
REQ-030 SHALL implement storage as one sub-module, byte_fifo (parameter DEPTH, 8-bit, registered output); conversion and counters stay in to_lower_stream.

Verification
REQ-031 SHALL cover: bytes 0x48, 0x41, 0x5A, 0x47 with out_ready=1 -> 0x68, 0x61, 0x7A, 0x67, each one cycle after acceptance; conv_count=4.
REQ-032 SHALL cover: bytes 0x40, 0x5B, 0x61, 0x7F, 0xC1, 0x28 -> output byte-identical; conv_count unchanged, byte_count +6.
REQ-033 SHALL cover: out_ready=0, 5 bytes offered with DEPTH=4 -> in_ready drops after 4th accept; 5th held; out_data stable; after out_ready=1, all 5 delivered in order.
REQ-034 SHALL cover: continuous in_valid=out_ready=1 for 20 bytes -> one byte per cycle, occupancy constant, pointers wrap with no loss.
REQ-035 SHALL cover: rst_n pulsed low with 3 bytes buffered -> out_valid=0 and counters 0 immediately; none of the 3 bytes emerge afterwards.
REQ-036 SHALL cover: byte_count preset near 0xFFFF by 65,540 accepts -> holds 0xFFFF; clr with a simultaneous accept -> 0.
